// File: rtl/pmpseqchk.sv
// pmpseqchk -- sequential PMP checker.
//
// One PMP address decoder is shared between the instruction-fetch (I) and
// data (D) requesters. A round-robin arbiter picks one request, then the
// entries are walked in index order, one per cycle. The TOR lower-bound
// result of entry i is carried into entry i+1. The walk stops at the
// lowest-numbered match, and a registered verdict is returned.
//
// Handshake: a requester raises its Req and holds it, with stable operands,
// until it sees its Ack. Ack is a one-cycle pulse. The matching Fault is
// valid only in that Ack cycle. A Req that is still high during its own Ack
// cycle is not a new request. Requests are only sampled in IDLE.
//
// Ports
//   clk, reset             clock, asynchronous active-low reset
//   IReq, IAdr             fetch request and physical address (4-byte access)
//   DReq, DAdr, DSize      data request, physical address, log2(bytes)
//   DRead, DWrite          data access type (both high = AMO)
//   PrivilegeMode          current privilege (2'b11 = M)
//   PMPCfg, PMPAdr         packed PMP CSR state; must be stable while Busy
//   IAck, DAck             one-cycle completion pulses
//   IFault, DFault         verdicts, qualified by the matching Ack
//   Busy                   high in SCAN and DONE
//   o_dbg_state            current FSM state (0 IDLE, 1 SCAN, 2 DONE)
module pmpseqchk #(
  parameter int PA_BITS   = 34,
  parameter int N_ENTRIES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              IReq,
  input  logic [PA_BITS-1:0]                IAdr,
  input  logic                              DReq,
  input  logic [PA_BITS-1:0]                DAdr,
  input  logic [1:0]                        DSize,
  input  logic                              DRead,
  input  logic                              DWrite,
  input  logic [1:0]                        PrivilegeMode,
  input  logic [8*N_ENTRIES-1:0]            PMPCfg,
  input  logic [N_ENTRIES*(PA_BITS-2)-1:0]  PMPAdr,
  output logic                              IAck,
  output logic                              DAck,
  output logic                              IFault,
  output logic                              DFault,
  output logic                              Busy,
  output logic [1:0]                        o_dbg_state
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int AW    = PA_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  state_t               r_state;
  logic                 r_favor_d;   // round-robin pointer: 1 = D has priority
  logic                 r_gnt_d;     // requester currently being served
  logic [PA_BITS-1:0]   r_adr;
  logic [1:0]           r_size;
  logic                 r_rd;
  logic                 r_wr;
  logic                 r_m;         // latched "privilege is M"
  logic [IDX_W-1:0]     r_idx;
  logic                 r_page;      // PA >= lower bound of entry r_idx
  logic                 r_fault;

  // ---------------------------------------------------------------------
  // Arbitration. A lone request is granted regardless of the pointer.
  // ---------------------------------------------------------------------
  logic w_grant_d;
  assign w_grant_d = DReq & (~IReq | r_favor_d);

  // ---------------------------------------------------------------------
  // Entry select for the shared decoder
  // ---------------------------------------------------------------------
  logic [7:0]    w_cfg;
  logic [AW-1:0] w_padr;

  always_comb begin
    w_cfg  = '0;
    w_padr = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cfg  = PMPCfg[8*i +: 8];
        w_padr = PMPAdr[AW*i +: AW];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shared address decoder
  // ---------------------------------------------------------------------
  logic [1:0]         w_a;
  logic               w_l;
  logic               w_x;
  logic               w_w;
  logic               w_r;
  logic [PA_BITS-1:0] w_top;
  logic [PA_BITS:0]   w_pa_plus4;
  logic               w_pa_lt;
  logic               w_pa4_lt;
  logic               w_tor_match;
  logic [AW-1:0]      w_nmask;
  logic               w_napot_match;
  logic               w_match;
  logic               w_unused;

  assign w_a   = w_cfg[4:3];
  assign w_l   = w_cfg[7];
  assign w_x   = w_cfg[2];
  assign w_w   = w_cfg[1];
  assign w_r   = w_cfg[0];
  assign w_unused = ^w_cfg[6:5];

  assign w_top      = {w_padr, 2'b00};
  assign w_pa_lt    = r_adr < w_top;
  assign w_pa_plus4 = {1'b0, r_adr} + (PA_BITS+1)'(4);
  assign w_pa4_lt   = w_pa_plus4 < {1'b0, w_top};

  // An 8-byte access must not straddle the top of a TOR region: the upper
  // word (PA+4) must also lie below the top.
  assign w_tor_match = r_page & w_pa_lt & ((r_size != 2'b11) | w_pa4_lt);

  // NAPOT: the trailing ones of pmpaddr plus the first zero mark the word
  // bits that are "don't care". PMPAdr ^ (PMPAdr+1) sets exactly those bits.
  // NA4 compares every word bit.
  assign w_nmask = (w_a == A_NA4) ? '1 : ~(w_padr ^ (w_padr + AW'(1)));
  assign w_napot_match = ((r_adr[PA_BITS-1:2] ^ w_padr) & w_nmask) == '0;

  always_comb begin
    w_match = 1'b0;
    case (w_a)
      A_OFF:   w_match = 1'b0;
      A_TOR:   w_match = w_tor_match;
      A_NA4,
      A_NAPOT: w_match = w_napot_match;
      default: w_match = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Verdict for a matching entry
  // ---------------------------------------------------------------------
  logic w_perm;
  logic w_hit_fault;
  logic w_last;

  always_comb begin
    w_perm = w_x;
    if (r_gnt_d) begin
      if (r_rd & r_wr)  w_perm = w_r & w_w;
      else if (r_wr)    w_perm = w_w;
      else              w_perm = w_r;
    end
  end

  // Locked entries bind M-mode too; unlocked entries let M through.
  assign w_hit_fault = ~((r_m & ~w_l) | w_perm);
  assign w_last      = r_idx == IDX_W'(N_ENTRIES-1);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_favor_d <= 1'b0;
      r_gnt_d   <= 1'b0;
      r_adr     <= '0;
      r_size    <= 2'b00;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_m       <= 1'b0;
      r_idx     <= '0;
      r_page    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (IReq | DReq) begin
            r_gnt_d   <= w_grant_d;
            r_favor_d <= ~w_grant_d;
            r_adr     <= w_grant_d ? DAdr : IAdr;
            r_size    <= w_grant_d ? DSize : 2'b10;
            r_rd      <= w_grant_d & DRead;
            r_wr      <= w_grant_d & DWrite;
            r_m       <= PrivilegeMode == 2'b11;
            r_idx     <= '0;
            r_page    <= 1'b1;   // entry 0's lower bound is address 0
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_fault <= w_hit_fault;
            r_state <= S_DONE;
          end else if (w_last) begin
            r_fault <= ~r_m;     // no entry matched: only M-mode is allowed
            r_state <= S_DONE;
          end else begin
            // The lower-bound result is carried even past OFF entries,
            // since a following TOR entry uses this pmpaddr as its base.
            r_page <= ~w_pa_lt;
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign IAck        = (r_state == S_DONE) & ~r_gnt_d;
  assign DAck        = (r_state == S_DONE) &  r_gnt_d;
  assign IFault      = IAck & r_fault;
  assign DFault      = DAck & r_fault;
  assign Busy        = r_state != S_IDLE;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pmpseqchk.sv
// Bench for pmpseqchk: directed steps followed by randomized requests. The
// expected verdict and latency come from a byte-range model of the PMP
// rules below.
module tb_pmpseqchk;

  localparam int PA_BITS = 34;
  localparam int N       = 4;
  localparam int AW      = PA_BITS - 2;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               reset;
  logic               IReq, DReq, DRead, DWrite;
  logic [PA_BITS-1:0] IAdr, DAdr;
  logic [1:0]         DSize, PrivilegeMode;
  logic [8*N-1:0]     PMPCfg;
  logic [N*AW-1:0]    PMPAdr;
  logic               IAck, DAck, IFault, DFault, Busy;
  logic [1:0]         dbg_state;

  logic [7:0]    cfg_arr[N];
  logic [AW-1:0] adr_arr[N];

  // Scoreboard record: {is_d, fault, latency[7:0]}
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign PMPCfg[8*g +: 8]   = cfg_arr[g];
    assign PMPAdr[AW*g +: AW] = adr_arr[g];
  end

  pmpseqchk #(.PA_BITS(PA_BITS), .N_ENTRIES(N)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAdr(IAdr),
    .DReq(DReq), .DAdr(DAdr), .DSize(DSize), .DRead(DRead), .DWrite(DWrite),
    .PrivilegeMode(PrivilegeMode), .PMPCfg(PMPCfg), .PMPAdr(PMPAdr),
    .IAck(IAck), .DAck(DAck), .IFault(IFault), .DFault(DFault), .Busy(Busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Walk the entries in order; the first whose byte range holds the access
  // decides. TOR requires the whole access inside [lo, hi); NA4/NAPOT test
  // the start address against the naturally aligned region.
  function automatic logic [9:0] model(input logic is_d, input logic [PA_BITS-1:0] pa,
                                       input logic [1:0] sz, input logic rd, input logic wr,
                                       input logic [1:0] priv);
    longint p, lo, hi, base, len, nbytes;
    int     k, lat;
    logic   m, hit, perm, fault;
    logic [7:0] c;
    m      = (priv == 2'b11);
    p      = longint'(pa);
    nbytes = is_d ? (64'd1 << sz) : 64'd4;
    hit    = 1'b0;
    lat    = N + 1;
    fault  = !m;
    for (int i = 0; i < N && !hit; i++) begin
      c  = cfg_arr[i];
      hi = longint'(adr_arr[i]) * 4;
      lo = (i == 0) ? 64'd0 : longint'(adr_arr[i-1]) * 4;
      case (c[4:3])
        2'd1: hit = (p >= lo) && (p + nbytes <= hi);
        2'd2: hit = (p >= hi) && (p < hi + 4);
        2'd3: begin
          k = 0;
          while (k < AW && adr_arr[i][k]) k++;
          len  = 64'd8 << k;
          base = ((longint'(adr_arr[i]) >> k) << k) * 4;
          hit  = (p >= base) && (p < base + len);
        end
        default: hit = 1'b0;
      endcase
      if (hit) begin
        lat = i + 2;
        if (!is_d)          perm = c[2];
        else if (rd && wr)  perm = c[0] & c[1];
        else if (wr)        perm = c[1];
        else                perm = c[0];
        fault = !((m && !c[7]) || perm);
      end
    end
    return {is_d, fault, 8'(lat)};
  endfunction

  // ---------------- drivers ----------------
  task automatic start_req(input logic is_d, input logic [PA_BITS-1:0] pa, input logic [1:0] sz,
                           input logic rd, input logic wr, input logic [1:0] priv);
    PrivilegeMode = priv;
    if (is_d) begin
      DAdr = pa; DSize = sz; DRead = rd; DWrite = wr; DReq = 1'b1;
    end else begin
      IAdr = pa; IReq = 1'b1;
    end
  endtask

  // Called at the negedge on which requests were raised (cycle 0 of the
  // request). Latency counts posedges from that point.
  task automatic wait_acks(input string tag);
    int c;
    logic [9:0] e;
    c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (IAck) begin
        check({tag, "_pending"}, exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_i_ack"}, {1'b0, IFault, 8'(c)}, e);
        end
        IReq = 1'b0;
      end
      if (DAck) begin
        check({tag, "_pending"}, exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_d_ack"}, {1'b1, DFault, 8'(c)}, e);
        end
        DReq = 1'b0;
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_timeout"}, 10'h3FF, e);
    end
    IReq = 1'b0;
    DReq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, {Busy, IAck, DAck}, 3'b000);
  endtask

  task automatic run_req(input string tag, input logic is_d, input logic [PA_BITS-1:0] pa,
                         input logic [1:0] sz, input logic rd, input logic wr,
                         input logic [1:0] priv, input logic [9:0] e);
    exp_q.push_back(e);
    start_req(is_d, pa, sz, rd, wr, priv);
    wait_acks(tag);
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_arr[i] = 8'h00;
      adr_arr[i] = '0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] rnd_e;
  logic       rnd_d, rnd_rd, rnd_wr;
  logic [1:0] rnd_sz, rnd_pv;
  logic [PA_BITS-1:0] rnd_pa;
  int         rnd_k, rnd_w;

  initial begin
    reset = 1'b0;
    IReq = 1'b0; DReq = 1'b0; DRead = 1'b0; DWrite = 1'b0;
    IAdr = '0; DAdr = '0; DSize = 2'b00; PrivilegeMode = 2'b00;
    clear_cfg();

    // 1. reset and idle
    repeat (3) @(negedge clk);
    check("reset_outputs", {Busy, IAck, DAck, IFault, DFault, dbg_state}, 7'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {Busy, IAck, DAck, IFault, DFault}, 5'd0);
    end

    // 5. arbitration just after reset (pointer favours I)
    clear_cfg();
    cfg_arr[0] = 8'h0D;           // TOR, X R
    adr_arr[0] = 32'h400;
    pulse_reset();
    exp_q.push_back({1'b0, 1'b0, 8'd2});
    exp_q.push_back({1'b1, 1'b0, 8'd5});
    start_req(1'b0, 34'h100, 2'b10, 1'b0, 1'b0, 2'b00);
    start_req(1'b1, 34'h200, 2'b10, 1'b1, 1'b0, 2'b00);
    wait_acks("arb_both1");
    exp_q.push_back({1'b0, 1'b0, 8'd2});
    exp_q.push_back({1'b1, 1'b1, 8'd5});   // write to R/X region faults
    start_req(1'b0, 34'h104, 2'b10, 1'b0, 1'b0, 2'b00);
    start_req(1'b1, 34'h204, 2'b10, 1'b0, 1'b1, 2'b00);
    wait_acks("arb_both2");
    run_req("arb_d_only", 1'b1, 34'h300, 2'b10, 1'b1, 1'b0, 2'b00, {1'b1, 1'b0, 8'd2});
    run_req("arb_d_only2", 1'b1, 34'h304, 2'b10, 1'b1, 1'b0, 2'b00, {1'b1, 1'b0, 8'd2});

    // 2. TOR read / write
    clear_cfg();
    cfg_arr[0] = 8'h09;           // TOR, R
    adr_arr[0] = 32'h400;
    run_req("tor_read",   1'b1, 34'h800, 2'b10, 1'b1, 1'b0, 2'b00, {1'b1, 1'b0, 8'd2});
    run_req("tor_write",  1'b1, 34'h800, 2'b10, 1'b0, 1'b1, 2'b00, {1'b1, 1'b1, 8'd2});
    run_req("tor_dw_end", 1'b1, 34'hFF8, 2'b11, 1'b1, 1'b0, 2'b00, {1'b1, 1'b0, 8'd2});
    run_req("tor_cross",  1'b1, 34'hFFC, 2'b11, 1'b1, 1'b0, 2'b00, {1'b1, 1'b1, 8'd5});
    run_req("tor_top",    1'b1, 34'h1000, 2'b10, 1'b1, 1'b0, 2'b00, {1'b1, 1'b1, 8'd5});

    // 3. NAPOT fetch
    cfg_arr[0] = 8'h00;
    cfg_arr[2] = 8'h1C;           // NAPOT, X
    adr_arr[2] = 32'h21FF;        // 4 KiB at 0x8000
    run_req("napot_hit",  1'b0, 34'h8010, 2'b10, 1'b0, 1'b0, 2'b00, {1'b0, 1'b0, 8'd4});
    run_req("napot_last", 1'b0, 34'h8FFC, 2'b10, 1'b0, 1'b0, 2'b00, {1'b0, 1'b0, 8'd4});
    run_req("napot_miss", 1'b0, 34'h9000, 2'b10, 1'b0, 1'b0, 2'b00, {1'b0, 1'b1, 8'd5});

    // 4. privilege and lock
    run_req("nomatch_s", 1'b1, 34'hF000_0000, 2'b10, 1'b1, 1'b0, 2'b01, {1'b1, 1'b1, 8'd5});
    run_req("nomatch_m", 1'b1, 34'hF000_0000, 2'b10, 1'b1, 1'b0, 2'b11, {1'b1, 1'b0, 8'd5});
    cfg_arr[0] = 8'h8C;           // L, TOR, X only
    adr_arr[0] = 32'h400;
    run_req("m_locked",   1'b1, 34'h100, 2'b10, 1'b1, 1'b0, 2'b11, {1'b1, 1'b1, 8'd2});
    cfg_arr[0] = 8'h0C;
    run_req("m_unlocked", 1'b1, 34'h100, 2'b10, 1'b1, 1'b0, 2'b11, {1'b1, 1'b0, 8'd2});

    // 6. reset mid-scan of a no-match request
    clear_cfg();
    start_req(1'b1, 34'h2000, 2'b10, 1'b1, 1'b0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("midscan_busy_before", Busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midscan_busy_after", {Busy, IAck, DAck}, 3'b000);
    repeat (3) begin
      @(negedge clk);
      check("midscan_no_ack", {Busy, IAck, DAck}, 3'b000);
    end
    reset = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 8'd5});
    wait_acks("midscan_resume");

    // Randomized requests against the model
    for (int t = 0; t < 48; t++) begin
      if (t % 8 == 0) begin
        for (int i = 0; i < N; i++) begin
          cfg_arr[i] = {1'($urandom_range(0, 1)), 2'b00, 2'($urandom_range(0, 3)),
                        3'($urandom_range(0, 7))};
          if (cfg_arr[i][4:3] == 2'd3) begin
            rnd_k = $urandom_range(0, 6);
            rnd_w = $urandom_range(0, 'h3FF);
            adr_arr[i] = AW'((rnd_w & ~((1 << (rnd_k + 1)) - 1)) | ((1 << rnd_k) - 1));
          end else begin
            adr_arr[i] = AW'($urandom_range(0, 'h400));
          end
        end
      end
      rnd_d  = 1'($urandom_range(0, 1));
      rnd_sz = rnd_d ? 2'($urandom_range(0, 3)) : 2'b10;
      rnd_rd = 1'($urandom_range(0, 1));
      rnd_wr = rnd_rd ? 1'($urandom_range(0, 1)) : 1'b1;
      case ($urandom_range(0, 2))
        0:       rnd_pv = 2'b00;
        1:       rnd_pv = 2'b01;
        default: rnd_pv = 2'b11;
      endcase
      rnd_pa = PA_BITS'($urandom_range(0, 'h1000));
      rnd_pa = rnd_pa & ~(PA_BITS'((1 << rnd_sz) - 1));
      rnd_e  = model(rnd_d, rnd_pa, rnd_sz, rnd_rd, rnd_wr, rnd_pv);
      run_req("random", rnd_d, rnd_pa, rnd_sz, rnd_rd, rnd_wr, rnd_pv, rnd_e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
